// File: rtl/fp8_bfly2.sv
// Radix-2 FP8 (E4M3) butterfly: x = A + WB, y = A - WB, two-stage valid/ready pipeline.
// Optional saturation-beat counter is compiled in only when FP8_BFLY_SAT_CNT_EN is defined.

module fp8_add_sub (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] y
);
  logic [17:0] mag_a, mag_b;
  logic [18:0] sum, rem, half;
  logic        sign_b, sign_r, rnd_up;
  logic [4:0]  msb, sh, q, e_out;

  // Magnitudes as integers in units of 2^-9 (the subnormal LSB), so the add is exact.
  function automatic logic [17:0] decode(input logic [7:0] c);
    if (c[6:3] == 4'd0) return {15'd0, c[2:0]};
    return 18'({1'b1, c[2:0]}) << (c[6:3] - 4'd1);
  endfunction

  always_comb begin
    mag_a  = decode(a);
    mag_b  = decode(b);
    sign_b = b[7] ^ sub;
    if (a[7] == sign_b) begin
      sum    = {1'b0, mag_a} + {1'b0, mag_b};
      sign_r = a[7];
    end else if (mag_a >= mag_b) begin
      sum    = {1'b0, mag_a - mag_b};
      sign_r = a[7];
    end else begin
      sum    = {1'b0, mag_b - mag_a};
      sign_r = sign_b;
    end
    msb = '0;
    for (int unsigned i = 0; i < 19; i++)
      if (sum[i]) msb = 5'(i);
    sh     = '0;
    q      = '0;
    rem    = '0;
    half   = '0;
    rnd_up = 1'b0;
    e_out  = '0;
    if (sum == '0) begin
      y = '0;
    end else if (sum < 19'd16) begin
      // Subnormals and exponent 1 share the unit step: the code equals the magnitude.
      y = {sign_r, sum[6:0]};
    end else begin
      sh     = msb - 5'd3;
      q      = 5'(sum >> sh);
      rem    = sum & ((19'd1 << sh) - 19'd1);
      half   = 19'd1 << (sh - 5'd1);
      rnd_up = (rem > half) || ((rem == half) && q[0]);
      q      = q + 5'(rnd_up);
      if (q[4]) begin
        q  = 5'd8;
        sh = sh + 5'd1;
      end
      e_out = sh + 5'd1;
      if (e_out > 5'd15) y = {sign_r, 7'h7F};
      else               y = {sign_r, e_out[3:0], q[2:0]};
    end
  end
endmodule

module fp8_bfly2 #(
  parameter int DIV2 = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a_re,
  input  logic [7:0]  a_im,
  input  logic [7:0]  wb_re,
  input  logic [7:0]  wb_im,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  x_re,
  output logic [7:0]  x_im,
  output logic [7:0]  y_re,
  output logic [7:0]  y_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sat_cnt
);
  logic       s1_valid, s2_valid, advance;
  logic [7:0] s1_a_re, s1_a_im, s1_wb_re, s1_wb_im;
  logic [7:0] sum_xr, sum_xi, dif_yr, dif_yi;

  function automatic logic [7:0] scale(input logic [7:0] c);
    if (DIV2 == 0)       return c;
    if (c[6:3] < 4'd2)   return 8'h00;
    return {c[7], c[6:3] - 4'd1, c[2:0]};
  endfunction

  assign advance   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || advance;
  assign out_valid = s2_valid;

  fp8_add_sub u_xr (.a(s1_a_re), .b(s1_wb_re), .sub(1'b0), .y(sum_xr));
  fp8_add_sub u_xi (.a(s1_a_im), .b(s1_wb_im), .sub(1'b0), .y(sum_xi));
  fp8_add_sub u_yr (.a(s1_a_re), .b(s1_wb_re), .sub(1'b1), .y(dif_yr));
  fp8_add_sub u_yi (.a(s1_a_im), .b(s1_wb_im), .sub(1'b1), .y(dif_yi));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_wb_re <= '0;
      s1_wb_im <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a_re  <= a_re;
        s1_a_im  <= a_im;
        s1_wb_re <= wb_re;
        s1_wb_im <= wb_im;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      x_re     <= '0;
      x_im     <= '0;
      y_re     <= '0;
      y_im     <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        x_re <= scale(sum_xr);
        x_im <= scale(sum_xi);
        y_re <= scale(dif_yr);
        y_im <= scale(dif_yi);
      end
    end
  end

`ifdef FP8_BFLY_SAT_CNT_EN
  logic s2_sat;
  assign s2_sat = (x_re[6:0] == 7'h7F) || (x_im[6:0] == 7'h7F) ||
                  (y_re[6:0] == 7'h7F) || (y_im[6:0] == 7'h7F);

  always_ff @(posedge clk) begin
    if (rst)
      sat_cnt <= '0;
    else if (out_valid && out_ready && s2_sat && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end
`else
  assign sat_cnt = '0;
`endif
endmodule

// File: tb/tb_fp8_bfly2.sv
// Bench for fp8_bfly2: DIV2=0 and DIV2=1 instances share stimulus and are checked
// every cycle against a real-arithmetic E4M3 model with an in-order scoreboard.
module tb_fp8_bfly2;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [7:0]  a_re, a_im, wb_re, wb_im;
  logic        in_ready, out_valid, h_in_ready, h_out_valid;
  logic [7:0]  x_re, x_im, y_re, y_im, h_x_re, h_x_im, h_y_re, h_y_im;
  logic [15:0] sat_cnt, h_sat_cnt;

  int unsigned n_chk = 0, n_err = 0, n_out = 0, mcyc = 0;
  logic [15:0] m_sat = '0, m_hsat = '0;

  typedef struct {
    logic [7:0]  xr, xi, yr, yi, hxr, hxi, hyr, hyi;
    logic        sat, hsat;
    int unsigned t;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  fp8_bfly2 #(.DIV2(0)) dut (
    .clk(clk), .rst(rst), .a_re(a_re), .a_im(a_im), .wb_re(wb_re), .wb_im(wb_im),
    .in_valid(in_valid), .in_ready(in_ready), .x_re(x_re), .x_im(x_im),
    .y_re(y_re), .y_im(y_im), .out_valid(out_valid), .out_ready(out_ready),
    .sat_cnt(sat_cnt));

  fp8_bfly2 #(.DIV2(1)) dut_h (
    .clk(clk), .rst(rst), .a_re(a_re), .a_im(a_im), .wb_re(wb_re), .wb_im(wb_im),
    .in_valid(in_valid), .in_ready(h_in_ready), .x_re(h_x_re), .x_im(h_x_im),
    .y_re(h_y_re), .y_im(h_y_im), .out_valid(h_out_valid), .out_ready(out_ready),
    .sat_cnt(h_sat_cnt));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp8_val(input logic [7:0] c);
    int  e = int'(c[6:3]);
    int  m = int'(c[2:0]);
    real mag;
    if (e == 0) mag = (m / 8.0) * pow2(-6);
    else        mag = (1.0 + m / 8.0) * pow2(e - 7);
    return c[7] ? -mag : mag;
  endfunction

  // Nearest representable magnitude, ties to even code; anything above max lands on 0x7F.
  function automatic logic [7:0] to_fp8(input real v);
    real mag = (v < 0.0) ? -v : v;
    real best_err = mag, err;
    logic [7:0] best = 8'h00, cd;
    for (int i = 1; i < 128; i++) begin
      cd  = 8'(i);
      err = fp8_val(cd) - mag;
      if (err < 0.0) err = -err;
      if (err < best_err || (err == best_err && cd[0] == 1'b0)) begin
        best_err = err;
        best     = cd;
      end
    end
    if (best == 8'h00) return 8'h00;
    return {(v < 0.0), best[6:0]};
  endfunction

  function automatic logic [7:0] add_model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    return to_fp8(sub ? fp8_val(a) - fp8_val(b) : fp8_val(a) + fp8_val(b));
  endfunction

  function automatic logic [7:0] half_model(input logic [7:0] c);
    if (c[6:3] < 4'd2) return 8'h00;
    return {c[7], c[6:3] - 4'd1, c[2:0]};
  endfunction

  function automatic logic is_sat(input logic [7:0] c);
    return c[6:0] == 7'h7F;
  endfunction

  function automatic beat_t make_beat(input logic [7:0] ar, ai, br, bi, input int unsigned t);
    beat_t b;
    b.xr  = add_model(ar, br, 1'b0);
    b.xi  = add_model(ai, bi, 1'b0);
    b.yr  = add_model(ar, br, 1'b1);
    b.yi  = add_model(ai, bi, 1'b1);
    b.hxr = half_model(b.xr);
    b.hxi = half_model(b.xi);
    b.hyr = half_model(b.yr);
    b.hyi = half_model(b.yi);
    b.sat  = is_sat(b.xr) || is_sat(b.xi) || is_sat(b.yr) || is_sat(b.yi);
    b.hsat = is_sat(b.hxr) || is_sat(b.hxi) || is_sat(b.hyr) || is_sat(b.hyi);
    b.t = t;
    return b;
  endfunction

  // Per-cycle compare process: samples between drive (negedge) and the next rising edge.
  initial begin
    beat_t b;
    logic  ov_exp;
    forever begin
      @(negedge clk); #2;
      mcyc++;
      if (rst) begin
        q.delete();
        m_sat  = '0;
        m_hsat = '0;
        continue;
      end
      ov_exp = (q.size() > 0) && ((mcyc - q[0].t) >= 2);
      check("out_valid", out_valid, ov_exp);
      check("h_out_valid", h_out_valid, ov_exp);
      if (ov_exp) begin
        b = q[0];
        check("x_re", x_re, b.xr);     check("x_im", x_im, b.xi);
        check("y_re", y_re, b.yr);     check("y_im", y_im, b.yi);
        check("h_x_re", h_x_re, b.hxr); check("h_x_im", h_x_im, b.hxi);
        check("h_y_re", h_y_re, b.hyr); check("h_y_im", h_y_im, b.hyi);
      end
      check("in_ready", in_ready, (q.size() < 2) || out_ready);
      check("h_in_ready", h_in_ready, (q.size() < 2) || out_ready);
      check("sat_cnt", sat_cnt, m_sat);
      check("h_sat_cnt", h_sat_cnt, m_hsat);
      if (ov_exp && out_ready) begin
        b = q.pop_front();
        n_out++;
`ifdef FP8_BFLY_SAT_CNT_EN
        if (b.sat && m_sat != 16'hFFFF)   m_sat  = m_sat + 16'd1;
        if (b.hsat && m_hsat != 16'hFFFF) m_hsat = m_hsat + 16'd1;
`endif
      end
      if (in_valid && in_ready)
        q.push_back(make_beat(a_re, a_im, wb_re, wb_im, mcyc));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic one_beat(input logic [7:0] ar, ai, br, bi);
    @(negedge clk);
    a_re = ar; a_im = ai; wb_re = br; wb_im = bi;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("lat_cycle1_valid", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned sent, out0;
    logic        stall_seen;
    logic [7:0]  bv [8][4];
    logic [15:0] sat_exp;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_re = '0; a_im = '0; wb_re = '0; wb_im = '0;

    // Hand-computed anchors for the model itself.
    check("model_1p1", add_model(8'h38, 8'h38, 1'b0), 16'h40);
    check("model_1m1", add_model(8'h38, 8'h38, 1'b1), 16'h00);
    check("model_sat", add_model(8'h7F, 8'h7F, 1'b0), 16'h7F);
    check("model_neg", add_model(8'h38, 8'h40, 1'b1), 16'hB8);
    check("model_half", half_model(8'h40), 16'h38);
    check("model_flush", half_model(8'h88), 16'h00);

    do_reset();
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_x_re", x_re, 8'h00);
    check("rst_sat", sat_cnt, 16'h0000);

    one_beat(8'h38, 8'h00, 8'h38, 8'h00);
    check("d_out_valid", out_valid, 1'b1);
    check("d_x_re", x_re, 8'h40);   check("d_x_im", x_im, 8'h00);
    check("d_y_re", y_re, 8'h00);   check("d_y_im", y_im, 8'h00);
    check("d_h_x_re", h_x_re, 8'h38); check("d_h_y_re", h_y_re, 8'h00);
    @(posedge clk); #1;
    check("d_pulse_end", out_valid, 1'b0);

    one_beat(8'h08, 8'h00, 8'h00, 8'h00);
    check("f_x_re", x_re, 8'h08);
    check("f_h_x_re", h_x_re, 8'h00);
    @(posedge clk); #1;

    do_reset();
    one_beat(8'h7F, 8'h00, 8'h7F, 8'h00);
    check("s_x_re", x_re, 8'h7F);
    check("s_pre_cnt", sat_cnt, 16'h0000);
    @(posedge clk); #1;
`ifdef FP8_BFLY_SAT_CNT_EN
    sat_exp = 16'h0001;
`else
    sat_exp = 16'h0000;
`endif
    check("s_post_cnt", sat_cnt, sat_exp);
    check("s_h_cnt", h_sat_cnt, 16'h0000);

    // Fill both stages, then reset mid-stream.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0;
    a_re = 8'h7F; a_im = 8'h7F; wb_re = 8'h7F; wb_im = 8'h7F;
    repeat (3) @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("mr_out_valid", out_valid, 1'b0);
    check("mr_x", {x_re, x_im}, 16'h0000);
    check("mr_y", {y_re, y_im}, 16'h0000);
    check("mr_sat", sat_cnt, 16'h0000);
    check("mr_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;

    // Eight back-to-back beats with a four-cycle output stall.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) bv[i][j] = 8'($urandom_range(0, 255));
    sent = 0; stall_seen = 1'b0; out0 = n_out;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a_re = bv[sent][0]; a_im = bv[sent][1]; wb_re = bv[sent][2]; wb_im = bv[sent][3];
      end
      #1;
      if (!in_ready) stall_seen = 1'b1;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check("b2b_stall_seen", stall_seen, 1'b1);
    check("b2b_sent", 16'(sent), 16'd8);
    check("b2b_delivered", 16'(n_out - out0), 16'd8);

    // Random valid/ready traffic with one reset in the middle.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      rst       = (c == 500);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_re  = 8'($urandom_range(0, 255));
      a_im  = 8'($urandom_range(0, 255));
      wb_re = 8'($urandom_range(0, 255));
      wb_im = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    check("drain_empty", 16'(q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
